// File: rtl/mem_access.sv
// RISC-V memory-access stage: request/ack data-memory transaction, load alignment/extension, stall control.
// Optional MEM_ALIGN_CHECK_EN adds the misalign_err port and suppresses misaligned requests.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic [6:0]  mem_opcode,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_mem_addr,
   input  logic [31:0] mem_mem_reg_data,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        stallreq,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        misalign_err
`endif
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state;
   logic [31:0] rbuf;
   logic        is_load, is_store, is_mem, start;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   always_comb begin
      is_load = 1'b0;
      if (mem_opcode == OP_LOAD) begin
         case (mem_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
            default:                                is_load = 1'b0;
         endcase
      end
   end

   assign is_store = (mem_opcode == OP_STORE) &&
                     ((mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) || (mem_funct3 == 3'b010));
   assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = ((mem_funct3[1:0] == 2'b01) && mem_mem_addr[0]) ||
                       ((mem_funct3[1:0] == 2'b10) && (mem_mem_addr[1:0] != 2'b00));
   assign start      = is_mem && !misaligned;
`else
   assign start      = is_mem;
`endif

   // Store lane selection; loads always fetch the full word.
   always_comb begin
      be_n    = 4'b1111;
      wdata_n = '0;
      if (is_store) begin
         case (mem_funct3[1:0])
            2'b00: begin
               be_n    = 4'b0001 << mem_mem_addr[1:0];
               wdata_n = {4{mem_mem_reg_data[7:0]}};
            end
            2'b01: begin
               be_n    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
               wdata_n = {2{mem_mem_reg_data[15:0]}};
            end
            default: begin
               be_n    = 4'b1111;
               wdata_n = mem_mem_reg_data;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         rbuf       <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_store;
                  dmem_addr  <= {mem_mem_addr[31:2], 2'b00};
                  dmem_be    <= be_n;
                  dmem_wdata <= wdata_n;
                  state      <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (dmem_ack) begin
                  rbuf     <= dmem_rdata;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  dmem_be  <= '0;
                  state    <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      case (mem_mem_addr[1:0])
         2'b00:   ld_byte = rbuf[7:0];
         2'b01:   ld_byte = rbuf[15:8];
         2'b10:   ld_byte = rbuf[23:16];
         default: ld_byte = rbuf[31:24];
      endcase
      ld_half = mem_mem_addr[1] ? rbuf[31:16] : rbuf[15:0];
      case (mem_funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = rbuf;
      endcase
   end

   // Writeback outputs are combinational, so reset must force them low explicitly.
   always_comb begin
      wb_wd    = mem_wd;
      wb_wreg  = mem_wreg;
      wb_wdata = mem_wdata;
      stallreq = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err = 1'b0;
`endif
      if (!rst) begin
         wb_wd    = '0;
         wb_wreg  = 1'b0;
         wb_wdata = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_mem) begin
                  wb_wreg = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                  if (misaligned) misalign_err = 1'b1;
                  else            stallreq     = 1'b1;
`else
                  stallreq = 1'b1;
`endif
               end
            end
            S_BUSY: begin
               stallreq = 1'b1;
               wb_wreg  = 1'b0;
            end
            S_DONE: begin
               if (is_load) wb_wdata = ld_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline, sitting between the EX/MEM pipeline register and MEM/WB.
- Decodes the latched load/store fields (opcode, funct3, address, store data) and runs a request/acknowledge transaction on the data-memory port.
- Aligns and extends load data, and presents the writeback triple to MEM/WB.
- Holds the pipeline through `stallreq` while a transaction is outstanding.
- Non-memory instructions pass straight through with zero latency.

## Interface
- Parameters: none.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mem_wd  in  5  destination register from EX/MEM.
- mem_wreg  in  1  register-write enable from EX/MEM.
- mem_wdata  in  32  ALU result from EX/MEM.
- mem_opcode  in  7  instruction opcode from EX/MEM.
- mem_funct3  in  3  instruction bits 14:12 from EX/MEM.
- mem_mem_addr  in  32  effective byte address.
- mem_mem_reg_data  in  32  store source (rs2) value.
- wb_wd  out  5  destination register to MEM/WB.
- wb_wreg  out  1  write enable to MEM/WB.
- wb_wdata  out  32  writeback data to MEM/WB.
- stallreq  out  1  stall request to the pipeline controller.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store, 0 = load, registered.
- dmem_addr  out  32  word address: `{mem_mem_addr[31:2], 2'b00}`, registered.
- dmem_be  out  4  byte enables, registered.
- dmem_wdata  out  32  store data with lane replication, registered.
- dmem_ack  in  1  memory completion, single-cycle pulse.
- dmem_rdata  in  32  read data, valid while `dmem_ack` = 1.
- misalign_err  out  1  misaligned access flag; only present with `MEM_ALIGN_CHECK_EN`.

## Operation
- Opcodes:
  - LOAD = 7'b0000011. funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - STORE = 7'b0100011. funct3: SB 000, SH 001, SW 010.
  - Any other opcode, or any other funct3, is a non-memory op.
- FSM state IDLE:
  - Non-memory op: `wb_*` = `mem_*` combinationally; `stallreq` = 0.
  - Memory op: `stallreq` = 1. On the clock edge, load the `dmem_*` registers, set `dmem_req` = 1, go to BUSY.
- FSM state BUSY:
  - `stallreq` = 1; `dmem_req` held high; all `dmem_*` outputs held stable.
  - When `dmem_ack` = 1 at an edge: capture `dmem_rdata` into `rbuf`, clear `dmem_req`/`dmem_we`/`dmem_be`, go to DONE.
- FSM state DONE:
  - `stallreq` = 0.
  - Load: `wb_wdata` = extended `rbuf`, `wb_wreg` = `mem_wreg`.
  - Store: `wb_*` pass through from `mem_*`.
  - Next edge: return to IDLE unconditionally. The next instruction enters at that edge.
- While in IDLE or BUSY with a memory op pending, `wb_wreg` = 0. MEM/WB is bubbled by the controller in this case.
- Byte lane select uses `mem_mem_addr[1:0]`:
  - SB: `be` = `4'b0001 << addr[1:0]`; `wdata` = byte replicated ×4.
  - SH: `be` = `addr[1]` ? `4'b1100` : `4'b0011`; `wdata` = halfword replicated ×2.
  - SW: `be` = `4'b1111`.
  - Loads: `be` = `4'b1111`.
- Load extension:
  - LB/LH: sign-extend the selected byte/half to 32 bits.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- EX/MEM inputs are held stable by the controller while `stallreq` = 1. The block never re-samples them mid-transaction except for combinational decode.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State → IDLE; `rbuf` = 0.
  - `dmem_req`, `dmem_we` = 0; `dmem_addr`, `dmem_be`, `dmem_wdata` = 0; `misalign_err` = 0.
  - `wb_wd`, `wb_wreg`, `wb_wdata`, `stallreq` = 0.
- Reset mid-BUSY: `dmem_req` drops immediately and the transaction is abandoned. The memory controller shares `rst`.
- Latency: op appears in cycle T; `dmem_req` rises at T+1; `dmem_ack` is sampled at the end of cycle T+k, k ≥ 1; DONE is cycle T+k+1.
  - `stallreq` is high for cycles T..T+k, i.e. minimum 2 cycles.
- `dmem_ack` in IDLE or DONE is ignored.
- Back-to-back memory ops: DONE → IDLE, then the new op is detected with no lost cycle beyond DONE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned cases are LH/LHU/SH with `addr[0]` = 1, and LW/SW with `addr[1:0]` ≠ 0.
  - On a misaligned op in IDLE: no request is issued; `stallreq` = 0; `wb_wreg` = 0; `misalign_err` = 1 combinationally for that cycle. State stays IDLE.
- `MEM_ALIGN_CHECK_EN` undefined:
  - The `misalign_err` port is absent.
  - Word accesses ignore `addr[1:0]`; half accesses ignore `addr[0]`. No fault is raised.

## Test plan
- LW at 0x100, ack 2 cycles after `req` rises, `rdata` = 0xDEADBEEF → `stallreq` high 3 cycles, `dmem_addr` = 0x100, `be` = 1111, DONE `wb_wdata` = 0xDEADBEEF, `wb_wreg` = 1.
- LB / LBU / LH at 0x103 / 0x103 / 0x102 with `rdata` = 0x80FF1234 → `wb_wdata` = 0xFFFFFF80 / 0x00000080 / 0xFFFF80FF.
- SB at 0x101 with `mem_mem_reg_data` = 0x000000AB → `we` = 1, `dmem_addr` = 0x100, `be` = 0010, `dmem_wdata` = 0xABABABAB. SH at 0x102 with 0x00001234 → `be` = 1100, `dmem_wdata` = 0x12341234.
- ADD with `mem_wdata` = 0x5, `mem_wd` = 7 → same-cycle passthrough, `stallreq` = 0, no `dmem_req`.
- `rst` = 0 asserted in BUSY → `dmem_req`, `stallreq` = 0 immediately; after release, state is IDLE and a fresh LW completes normally.
- `MEM_ALIGN_CHECK_EN` defined: LW at 0x102 → `misalign_err` = 1 for one cycle, `dmem_req` never rises, `wb_wreg` = 0.
